// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: arbiter FSM states, master ids and RamMode bit positions.
// Used by the core, the RAM wrapper and the data-bus arbiter.
package dbus_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam int M_CORE = 0;
    localparam int M_AUX  = 1;

    // RamMode is a 4-bit field; these are its bit indices.
    localparam int RM_BYTE = 3;
    localparam int RM_HALF = 2;
    localparam int RM_WORD = 1;
    localparam int RM_UNS  = 0;

    // Returns the index of the master that is not m (only two masters).
    function automatic logic other_master(input logic m);
        return ~m;
    endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of the two master request/return channels and the single slave port of the data bus.
interface dbus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Handshake: a master raises mN_req with we/addr/wdata/mode stable and holds them
    // until mN_gnt is seen high in the same cycle; the access is taken at that clock edge.
    // A read returns later as a single-cycle mN_rvalid with mN_rdata (rdata is 0 otherwise).
    // The slave samples s_* whenever s_en is high and answers reads with one s_rvalid pulse.
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_mode;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [3:0]    m1_mode;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          s_en;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_mode;
    logic [DW-1:0] s_rdata;
    logic          s_rvalid;

    modport arb (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_en, s_we, s_addr, s_wdata, s_mode,
        input  s_rdata, s_rvalid
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    modport slave (
        input  s_en, s_we, s_addr, s_wdata, s_mode,
        output s_rdata, s_rvalid
    );

endinterface

// File: rtl/dbus_pick2.sv
// Combinational two-way picker producing a one-hot winner.
// DBUS_RR_EN selects round-robin on contention; otherwise master 0 has fixed priority.
module dbus_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       rr_en_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o = req_i;
        if (req_i == 2'b11) begin
`ifdef DBUS_RR_EN
            // Contention: the master that was not granted last goes next.
            pick_o = (rr_en_i && !last_i) ? 2'b10 : 2'b01;
`else
            pick_o = 2'b01;
`endif
        end
    end

`ifndef DBUS_RR_EN
    logic unused_cfg;
    assign unused_cfg = last_i ^ rr_en_i;
`endif

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master / one-slave data RAM arbiter: zero-latency grant, slave held across a read.
// Arbitration is fixed priority unless DBUS_RR_EN is defined (round-robin).
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic     clk,
    input  logic     rstB,
    dbus_arbiter_if.arb bus,
    output logic     dbg_state_o
);

    localparam logic [0:0] ST_IDLE    = 1'(IDLE);
    localparam logic [0:0] ST_RD_WAIT = 1'(RD_WAIT);

`ifdef DBUS_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic [0:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;

    logic [1:0]    req;
    logic [1:0]    pick;
    logic          win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [3:0]    sel_mode;

    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic          s_en;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_mode;

    assign req = {bus.m1_req, bus.m0_req};

    dbus_pick2 u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .rr_en_i (RR_EN),
        .pick_o  (pick)
    );

    assign win       = pick[M_AUX];
    assign sel_we    = win ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    assign sel_mode  = win ? bus.m1_mode  : bus.m0_mode;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt     = 2'b00;
        rvalid  = 2'b00;
        s_en    = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_mode  = '0;
        case (state_q)
            ST_IDLE: begin
                // s_rvalid here is spurious and deliberately not looked at.
                if (|pick) begin
                    s_en    = 1'b1;
                    s_we    = sel_we;
                    s_addr  = sel_addr;
                    s_wdata = sel_wdata;
                    s_mode  = sel_mode;
                    gnt     = pick;
                    last_d  = win;
                    if (!sel_we) begin
                        owner_d = win;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (bus.s_rvalid) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign bus.m0_gnt    = gnt[M_CORE];
    assign bus.m1_gnt    = gnt[M_AUX];
    assign bus.m0_rvalid = rvalid[M_CORE];
    assign bus.m1_rvalid = rvalid[M_AUX];
    assign bus.m0_rdata  = rvalid[M_CORE] ? bus.s_rdata : '0;
    assign bus.m1_rdata  = rvalid[M_AUX]  ? bus.s_rdata : '0;
    assign bus.s_en      = s_en;
    assign bus.s_we      = s_we;
    assign bus.s_addr    = s_addr;
    assign bus.s_wdata   = s_wdata;
    assign bus.s_mode    = s_mode;
    assign dbg_state_o   = state_q;

endmodule
